// File: rtl/video_render_buf_if.sv
// video_render_buf_if: fetch handshake, render control, font port and pixel output of the renderer.
interface video_render_buf_if #(
   parameter int FETCH_W = 64
);
   logic [FETCH_W-1:0] pic_bits;
   logic               pic_valid;
   logic               pic_ready;
   logic               line_start;
   logic               pix_stb;
   logic               int_start;
   logic [2:0]         mode;
   logic [2:0]         typos;
   logic [3:0]         border;
   logic               underrun_clr;
   logic [10:0]        font_addr;
   logic [7:0]         font_q;
   logic [3:0]         pixels;
   logic               pix_valid;
   logic               underrun;
   modport master (
      output pic_bits, pic_valid, line_start, pix_stb, int_start, mode, typos, border,
             underrun_clr, font_q,
      input  pic_ready, font_addr, pixels, pix_valid, underrun
   );
   modport slave (
      input  pic_bits, pic_valid, line_start, pix_stb, int_start, mode, typos, border,
             underrun_clr, font_q,
      output pic_ready, font_addr, pixels, pix_valid, underrun
   );
endinterface

// File: rtl/video_render_buf.sv
// video_render_buf: renders fetched video words into 4-bit pixels through a render+shadow buffer pair.
// Define VIDEO_RENDER_OUTREG_EN to add an output register stage on pixels/pix_valid (latency 2).
module video_render_buf #(
   parameter int FETCH_W    = 64,
   parameter int FLASH_BITS = 5
) (
   input logic               clk,
   input logic               rst,
   video_render_buf_if.slave bus
);
   localparam int G  = FETCH_W / 16;
   localparam int IW = $clog2(8 * G);
   localparam logic [IW-1:0] LAST_ATTR = IW'(8 * G - 1);
   localparam logic [IW-1:0] LAST_16C  = IW'(4 * G - 1);

   logic [FETCH_W-1:0]    render_q, render_d, shadow_q, shadow_d;
   logic                  render_full_q, render_full_d, shadow_full_q, shadow_full_d;
   logic [IW-1:0]         idx_q, idx_d, grp_idx;
   logic [2:0]            mode_q, mode_d;
   logic [FLASH_BITS-1:0] flash_q, flash_d;
   logic [3:0]            pix_q, pix_d;
   logic                  pv_q, pv_d, underrun_q, underrun_d;
   logic                  is_16c, is_text, zx_like;
   logic [15:0]           grp;
   logic [7:0]            pixbyte, attr, src, byt;
   logic                  pixbit;
   logic [3:0]            ink, paper, attr_pix, c16_pix, pix_val;
   logic                  accept, stb, draw, last, free;

   always_comb begin
      is_16c   = (mode_q == 3'd1) || (mode_q == 3'd4);
      is_text  = mode_q == 3'd5;
      zx_like  = (mode_q == 3'd0) || (mode_q == 3'd2) || (mode_q >= 3'd6);
      grp_idx  = is_16c ? idx_q >> 2 : idx_q >> 3;
      grp      = 16'(render_q >> {grp_idx, 4'd0});
      pixbyte  = grp[15:8];
      attr     = grp[7:0];
      src      = is_text ? bus.font_q : pixbyte;
      pixbit   = src[~idx_q[2:0]] ^ (zx_like & flash_q[FLASH_BITS-1] & attr[7]);
      ink      = {attr[6], attr[2:0]};
      paper    = {zx_like ? attr[6] : attr[7], attr[5:3]};
      attr_pix = pixbit ? ink : paper;
      byt      = idx_q[1] ? pixbyte : attr;
      c16_pix  = idx_q[0] ? {byt[7], byt[5:3]} : {byt[6], byt[2:0]};
      pix_val  = is_16c ? c16_pix : attr_pix;
   end

   // pic_ready is ~shadow_full_q, so an accept never coincides with a full shadow.
   always_comb begin
      accept        = bus.pic_valid & ~shadow_full_q;
      stb           = bus.pix_stb & ~bus.line_start;
      draw          = stb & render_full_q;
      last          = idx_q == (is_16c ? LAST_16C : LAST_ATTR);
      free          = ~render_full_q | (draw & last);
      render_full_d = bus.line_start ? accept : free ? (shadow_full_q | accept) : 1'b1;
      render_d      = (bus.line_start | (free & ~shadow_full_q)) ? bus.pic_bits :
                      free ? shadow_q : render_q;
      shadow_full_d = ~bus.line_start & ~free & (shadow_full_q | accept);
      shadow_d      = accept ? bus.pic_bits : shadow_q;
      idx_d         = bus.line_start ? '0 : draw ? (last ? '0 : idx_q + IW'(1)) : idx_q;
      mode_d        = bus.line_start ? bus.mode : mode_q;
      flash_d       = flash_q + FLASH_BITS'(bus.int_start);
      pv_d          = stb;
      pix_d         = stb ? (render_full_q ? pix_val : bus.border) : pix_q;
      underrun_d    = (stb & ~render_full_q) | (underrun_q & ~bus.underrun_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         render_q      <= '0;
         shadow_q      <= '0;
         render_full_q <= 1'b0;
         shadow_full_q <= 1'b0;
         idx_q         <= '0;
         mode_q        <= '0;
         flash_q       <= '0;
         pix_q         <= '0;
         pv_q          <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         render_q      <= render_d;
         shadow_q      <= shadow_d;
         render_full_q <= render_full_d;
         shadow_full_q <= shadow_full_d;
         idx_q         <= idx_d;
         mode_q        <= mode_d;
         flash_q       <= flash_d;
         pix_q         <= pix_d;
         pv_q          <= pv_d;
         underrun_q    <= underrun_d;
      end
   end

`ifdef VIDEO_RENDER_OUTREG_EN
   logic [3:0] pix2_q;
   logic       pv2_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         pix2_q <= '0;
         pv2_q  <= 1'b0;
      end else begin
         pix2_q <= pix_q;
         pv2_q  <= pv_q;
      end
   end
   assign bus.pixels    = pix2_q;
   assign bus.pix_valid = pv2_q;
`else
   assign bus.pixels    = pix_q;
   assign bus.pix_valid = pv_q;
`endif

   assign bus.pic_ready = ~shadow_full_q;
   assign bus.underrun  = underrun_q;
   assign bus.font_addr = {bus.typos, pixbyte};
endmodule
